// File: rtl/pmm_pkg.sv
// Shared definitions for the PMM command sequencer: opcodes, memory size,
// FSM state encoding and the buffered command record.
package pmm_pkg;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_CHAR  = 2'b10;
   localparam logic [1:0] OP_RESET = 2'b11;

   localparam int PMM_MEM_WORDS = 517;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DROP = 2'd2
   } pmm_state_e;

   typedef struct packed {
      logic [1:0]  op;
      logic [13:0] addr;
      logic [63:0] data;
   } pmm_cmd_t;

   localparam int PMM_CMD_W = $bits(pmm_cmd_t);

   // Word index lives in addr[13:3]; the PMM rejects anything past its last word.
   function automatic logic addr_legal(input logic [13:0] addr);
      return int'(addr[13:3]) < PMM_MEM_WORDS;
   endfunction

endpackage

// File: rtl/pmm_cmd_fifo.sv
// Synchronous FIFO for host commands; pointers carry one extra wrap bit so
// full and empty can be told apart.
module pmm_cmd_fifo #(
   parameter int WIDTH = 80,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/pmm_cmd_sequencer.sv
// Buffers host commands and feeds them to the PMM with a four-phase handshake.
// Optional handshake watchdog enabled by defining PMM_TIMEOUT_EN.
module pmm_cmd_sequencer
   import pmm_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int POS_W          = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [1:0]       s_op,
   input  logic [13:0]      s_addr,
   input  logic [63:0]      s_data,
   output logic [63:0]      pmm_data,
   output logic [15:0]      pmm_control,
   output logic             pmm_valid,
   input  logic             pmm_ready,
   input  logic             pmm_accepted,
   output logic             match_valid,
   output logic [POS_W-1:0] match_pos,
   output logic [POS_W-1:0] char_count,
   output logic             busy,
   output logic             addr_err,
   output logic             timeout_err
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic             fifo_full, fifo_empty, fifo_pop;
   logic [PMM_CMD_W-1:0] fifo_dout;
   pmm_cmd_t         head;

   pmm_state_e       state_q, state_d;
   logic [63:0]      pmm_data_q, pmm_data_d;
   logic [15:0]      pmm_control_q, pmm_control_d;
   logic             pmm_valid_q, pmm_valid_d;
   logic             match_valid_q, match_valid_d;
   logic [POS_W-1:0] match_pos_q, match_pos_d;
   logic [POS_W-1:0] char_count_q, char_count_d;
   logic             addr_err_q, addr_err_d;

   pmm_cmd_fifo #(
      .WIDTH (PMM_CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_valid),
      .din   ({s_op, s_addr, s_data}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head = pmm_cmd_t'(fifo_dout);

`ifdef PMM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          timeout_err_q, timeout_err_d;
   logic          tmo_hit;
   assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_d       = state_q;
      pmm_data_d    = pmm_data_q;
      pmm_control_d = pmm_control_q;
      pmm_valid_d   = pmm_valid_q;
      match_valid_d = 1'b0;
      match_pos_d   = match_pos_q;
      char_count_d  = char_count_q;
      addr_err_d    = addr_err_q;
      fifo_pop      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (head.op == OP_WRITE && !addr_legal(head.addr)) begin
                  addr_err_d = 1'b1;
               end else begin
                  pmm_data_d    = head.data;
                  // Non-write ops carry a zero address so the PMM address check passes.
                  pmm_control_d = {head.op, (head.op == OP_WRITE) ? head.addr : 14'd0};
                  pmm_valid_d   = 1'b1;
                  state_d       = ST_WAIT_ACK;
               end
            end
         end
         ST_WAIT_ACK: begin
            if (pmm_ready) begin
               pmm_valid_d = 1'b0;
               state_d     = ST_WAIT_DROP;
               if (pmm_control_q[15:14] == OP_CHAR) begin
                  match_valid_d = pmm_accepted;
                  if (pmm_accepted) match_pos_d = char_count_q;
                  char_count_d = char_count_q + {{(POS_W-1){1'b0}}, 1'b1};
               end else if (pmm_control_q[15:14] == OP_RESET) begin
                  char_count_d = '0;
               end
            end
         end
         ST_WAIT_DROP: begin
            if (!pmm_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef PMM_TIMEOUT_EN
      timeout_err_d = timeout_err_q;
      tmo_cnt_d     = tmo_cnt_q + TW'(1);
      if (state_d != state_q) tmo_cnt_d = '0;
      // A stalled phase abandons the command: no match, no count update.
      if (((state_q == ST_WAIT_ACK && !pmm_ready) ||
           (state_q == ST_WAIT_DROP && pmm_ready)) && tmo_hit) begin
         timeout_err_d = 1'b1;
         pmm_valid_d   = 1'b0;
         state_d       = ST_IDLE;
         tmo_cnt_d     = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         pmm_data_q    <= '0;
         pmm_control_q <= '0;
         pmm_valid_q   <= 1'b0;
         match_valid_q <= 1'b0;
         match_pos_q   <= '0;
         char_count_q  <= '0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pmm_data_q    <= pmm_data_d;
         pmm_control_q <= pmm_control_d;
         pmm_valid_q   <= pmm_valid_d;
         match_valid_q <= match_valid_d;
         match_pos_q   <= match_pos_d;
         char_count_q  <= char_count_d;
         addr_err_q    <= addr_err_d;
      end
   end

`ifdef PMM_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign s_ready     = !fifo_full;
   assign pmm_data    = pmm_data_q;
   assign pmm_control = pmm_control_q;
   assign pmm_valid   = pmm_valid_q;
   assign match_valid = match_valid_q;
   assign match_pos   = match_pos_q;
   assign char_count  = char_count_q;
   assign addr_err    = addr_err_q;
   assign busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_pmm_cmd_sequencer.sv
// Scoreboard bench for pmm_cmd_sequencer with a behavioural PMM responder.
module tb_pmm_cmd_sequencer;

   localparam int POS_W   = 32;
   localparam int ACK_DLY = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic [1:0]       s_op;
   logic [13:0]      s_addr;
   logic [63:0]      s_data;
   logic [63:0]      pmm_data;
   logic [15:0]      pmm_control;
   logic             pmm_valid;
   logic             pmm_ready;
   logic             pmm_accepted;
   logic             match_valid;
   logic [POS_W-1:0] match_pos;
   logic [POS_W-1:0] char_count;
   logic             busy;
   logic             addr_err;
   logic             timeout_err;

   always #5 clk = ~clk;

   pmm_cmd_sequencer #(
      .FIFO_DEPTH     (4),
      .POS_W          (POS_W),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_op         (s_op),
      .s_addr       (s_addr),
      .s_data       (s_data),
      .pmm_data     (pmm_data),
      .pmm_control  (pmm_control),
      .pmm_valid    (pmm_valid),
      .pmm_ready    (pmm_ready),
      .pmm_accepted (pmm_accepted),
      .match_valid  (match_valid),
      .match_pos    (match_pos),
      .char_count   (char_count),
      .busy         (busy),
      .addr_err     (addr_err),
      .timeout_err  (timeout_err)
   );

   typedef struct {
      logic [15:0] ctrl;
      logic [63:0] data;
   } exp_t;

   exp_t             exp_pmm[$];
   logic [POS_W-1:0] exp_match[$];
   int               n_checks = 0;
   int               n_pass   = 0;
   logic             stall = 1'b0;
   logic [7:0]       accept_char = 8'h63;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // PMM responder: raises ready ACK_DLY cycles after valid, drops it after valid falls.
   initial begin
      int cnt = 0;
      pmm_ready    = 1'b0;
      pmm_accepted = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (pmm_ready) begin
            if (!pmm_valid) begin
               pmm_ready    = 1'b0;
               pmm_accepted = 1'b0;
            end
         end else if (pmm_valid && !stall) begin
            cnt++;
            if (cnt >= ACK_DLY) begin
               pmm_ready    = 1'b1;
               pmm_accepted = (pmm_control[15:14] == 2'b10) && (pmm_data[7:0] == accept_char);
               cnt = 0;
            end
         end else if (!pmm_valid) begin
            cnt = 0;
         end
      end
   end

   // Monitor: checks each issued PMM command and each match pulse against the queues.
   initial begin
      logic prev_valid = 1'b0;
      logic prev_match = 1'b0;
      exp_t cur;
      cur.ctrl = '0;
      cur.data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
            prev_match = 1'b0;
         end else begin
            if (pmm_valid && !prev_valid) begin
               if (exp_pmm.size() == 0) begin
                  chk("pmm_cmd_unexpected", {48'd0, pmm_control}, 64'hFFFF_FFFF);
               end else begin
                  cur = exp_pmm.pop_front();
                  chk("pmm_control", {48'd0, pmm_control}, {48'd0, cur.ctrl});
                  chk("pmm_data", pmm_data, cur.data);
                  chk("ready_low_at_issue", {63'd0, pmm_ready}, 64'd0);
               end
            end else if (pmm_valid) begin
               chk("pmm_control_stable", {48'd0, pmm_control}, {48'd0, cur.ctrl});
               chk("pmm_data_stable", pmm_data, cur.data);
            end
            if (match_valid) begin
               chk("match_single_cycle", {63'd0, prev_match}, 64'd0);
               if (exp_match.size() == 0)
                  chk("match_unexpected", {32'd0, match_pos}, 64'hFFFF_FFFF);
               else
                  chk("match_pos", {32'd0, match_pos}, {32'd0, exp_match.pop_front()});
            end
            prev_valid = pmm_valid;
            prev_match = match_valid;
         end
      end
   end

   task automatic expect_cmd(input logic [15:0] ctrl, input logic [63:0] data);
      exp_t e;
      e.ctrl = ctrl;
      e.data = data;
      exp_pmm.push_back(e);
   endtask

   task automatic send(input logic [1:0] op, input logic [13:0] addr, input logic [63:0] data);
      int n = 0;
      while (!s_ready && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) chk("send_ready_wait_expired", 64'd1, 64'd0);
      s_valid = 1'b1;
      s_op    = op;
      s_addr  = addr;
      s_data  = data;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || pmm_valid || pmm_ready) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_idle_wait_expired"}, {63'd0, (n >= 300)}, 64'd0);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!pmm_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_valid_wait_expired"}, {63'd0, (n >= 50)}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got running, expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      int acc;
      int idx;
      logic can_push;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_op    = 2'b00;
      s_addr  = '0;
      s_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
      chk("rst_pmm_valid", {63'd0, pmm_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_addr_err", {63'd0, addr_err}, 64'd0);
      chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
      chk("rst_char_count", {32'd0, char_count}, 64'd0);
      chk("rst_match_valid", {63'd0, match_valid}, 64'd0);
      chk("rst_pmm_control", {48'd0, pmm_control}, 64'd0);

      // Legal write, then word 517 dropped, nop still issued, word 516 accepted.
      expect_cmd(16'h4808, 64'hA5);
      send(2'b01, 14'h0808, 64'hA5);
      wait_idle("write");
      send(2'b01, 14'h1028, 64'hDEAD);
      expect_cmd(16'h0000, 64'h7);
      send(2'b00, 14'h1234, 64'h7);
      wait_idle("bad_addr");
      chk("addr_err_set", {63'd0, addr_err}, 64'd1);
      expect_cmd(16'h5020, 64'h1);
      send(2'b01, 14'h1020, 64'h1);
      wait_idle("word516");

      // Reset state, then 'a','b','c' with a match on 'c'.
      expect_cmd(16'hC000, 64'h0);
      send(2'b11, 14'h0, 64'h0);
      expect_cmd(16'h8000, 64'h61);
      send(2'b10, 14'h3FFF, 64'h61);
      expect_cmd(16'h8000, 64'h62);
      send(2'b10, 14'h0, 64'h62);
      exp_match.push_back(32'd2);
      expect_cmd(16'h8000, 64'h63);
      send(2'b10, 14'h0, 64'h63);
      wait_idle("chars");
      chk("char_count_after_abc", {32'd0, char_count}, 64'd3);
      chk("match_pos_held", {32'd0, match_pos}, 64'd2);
      chk("match_queue_empty_abc", exp_match.size(), 64'd0);
      expect_cmd(16'hC000, 64'h0);
      send(2'b11, 14'h0, 64'h0);
      wait_idle("reset_op");
      chk("char_count_cleared", {32'd0, char_count}, 64'd0);

      // Stalled PMM: one command in flight, four more fill the FIFO.
      stall = 1'b1;
      expect_cmd(16'h4000, 64'h100);
      send(2'b01, 14'h0000, 64'h100);
      wait_valid("burst");
      acc = 0;
      idx = 1;
      for (int k = 0; k < 6; k++) begin
         s_valid = 1'b1;
         s_op    = 2'b01;
         s_addr  = 14'(idx << 3);
         s_data  = 64'(256 + idx);
         can_push = s_ready;
         if (can_push) expect_cmd({2'b01, 14'(idx << 3)}, 64'(256 + idx));
         @(posedge clk);
         #1;
         if (can_push) begin
            acc++;
            idx++;
         end
      end
      s_valid = 1'b0;
      chk("burst_accepted", acc, 64'd4);
      chk("burst_s_ready_low", {63'd0, s_ready}, 64'd0);
      stall = 1'b0;
      expect_cmd({2'b01, 14'(5 << 3)}, 64'(256 + 5));
      send(2'b01, 14'(5 << 3), 64'(256 + 5));
      wait_idle("burst");
      chk("burst_queue_drained", exp_pmm.size(), 64'd0);

      // Non-matching char, then reset while the next char waits for ack.
      expect_cmd(16'h8000, 64'h7A);
      send(2'b10, 14'h0, 64'h7A);
      wait_idle("char_z");
      chk("char_count_one", {32'd0, char_count}, 64'd1);
      stall = 1'b1;
      expect_cmd(16'h8000, 64'h78);
      send(2'b10, 14'h0, 64'h78);
      wait_valid("midrst");
      expect_cmd(16'h0000, 64'h11);
      send(2'b00, 14'h0, 64'h11);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_pmm.delete();
      chk("midrst_pmm_valid", {63'd0, pmm_valid}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_s_ready", {63'd0, s_ready}, 64'd1);
      chk("midrst_addr_err", {63'd0, addr_err}, 64'd0);
      chk("midrst_char_count", {32'd0, char_count}, 64'd0);
      chk("midrst_match_pos", {32'd0, match_pos}, 64'd0);
      stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expect_cmd(16'h0000, 64'h55);
      send(2'b00, 14'h0, 64'h55);
      wait_idle("after_rst");

`ifdef PMM_TIMEOUT_EN
      stall = 1'b1;
      expect_cmd(16'h0000, 64'h99);
      send(2'b00, 14'h0, 64'h99);
      wait_valid("tmo");
      acc = 0;
      while (!timeout_err && acc < 100) begin
         @(posedge clk);
         #1;
         acc++;
      end
      chk("timeout_cycles", acc, 64'd16);
      chk("timeout_err_set", {63'd0, timeout_err}, 64'd1);
      chk("timeout_pmm_valid", {63'd0, pmm_valid}, 64'd0);
      chk("timeout_busy", {63'd0, busy}, 64'd0);
      stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expect_cmd(16'h0000, 64'h77);
      send(2'b00, 14'h0, 64'h77);
      wait_idle("after_tmo");
`else
      chk("timeout_err_tied_low", {63'd0, timeout_err}, 64'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("pmm_queue_drained", exp_pmm.size(), 64'd0);
      chk("match_queue_drained", exp_match.size(), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pmm_cmd_sequencer.md
Name: pmm_cmd_sequencer

Overview:
- Upstream feeder for the pattern-matching module (PMM).
- Buffers host commands (bitmask writes, text characters, resets, no-ops) in a small FIFO, drives the PMM's data/control/valid interface with a four-phase handshake, and captures the accept flag.
- Reports the character index of every match as a one-cycle result pulse.
- Filters illegal bitmask addresses locally, so a bad write never reaches the PMM.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- POS_W, 32, width of the character-position counter.
- TIMEOUT_CYCLES, 1024, handshake watchdog limit; used only with PMM_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  host command valid.
- s_ready  out  1  FIFO not full; command accepted when s_valid&&s_ready.
- s_op  in  2  00 nop, 01 write mask, 10 character, 11 reset state.
- s_addr  in  14  mask address (word index = s_addr[13:3]).
- s_data  in  64  mask word, or character in [7:0].
- pmm_data  out  64  to PMM INP_DATA.
- pmm_control  out  16  to PMM INP_CONTROL = {op, addr}.
- pmm_valid  out  1  to PMM DATA_VALID.
- pmm_ready  in  1  from PMM READY_STATUS.
- pmm_accepted  in  1  from PMM ACCEPTED_STATUS.
- match_valid  out  1  one-cycle pulse: a character produced a match.
- match_pos  out  POS_W  index of the matching character (0-based since last op 11).
- char_count  out  POS_W  characters issued since last op 11.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- addr_err  out  1  sticky; set by a dropped illegal write.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset: all outputs 0; s_ready=1 after reset; FIFO empty; FSM=IDLE; counters 0; sticky flags cleared. Reset mid-transaction drops pmm_valid next edge and discards FIFO contents.
- FIFO: push on s_valid&&s_ready. s_ready = !full. Simultaneous push and pop when full is not allowed, because s_ready is already low. Pointers wrap modulo FIFO_DEPTH, with an extra bit for the full/empty distinction.
- FSM states: IDLE, WAIT_ACK, WAIT_DROP.
- IDLE with FIFO non-empty: pop one entry.
  - op 01 with s_addr[13:3] >= 517: drop the entry, set addr_err, stay in IDLE. No PMM cycle is issued.
  - Otherwise: register pmm_data, set pmm_control = {op, addr}, set pmm_valid=1, go to WAIT_ACK.
  - For ops 00/10/11, the addr field is forced to 0. This keeps the PMM address check passing.
  - pmm_valid rises 1 cycle after the pop edge. pmm_data/pmm_control stay stable while pmm_valid=1.
- WAIT_ACK: when pmm_ready=1 (same-cycle sample):
  - pmm_valid<=0; go to WAIT_DROP.
  - If op=10: match_valid<=pmm_accepted; match_pos<=char_count; char_count<=char_count+1. The counter wraps at 2^POS_W.
  - If op=11: char_count<=0.
- WAIT_DROP: wait for pmm_ready=0, then go to IDLE. The next pop can occur in the same cycle IDLE is entered, i.e. the following edge.
- Minimum 4 cycles per command when the PMM answers immediately.
- match_valid is high for exactly one cycle. match_pos holds its value until the next match.

Optional Feature:
- Macro PMM_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_ACK and on entry to WAIT_DROP.
  - If it reaches TIMEOUT_CYCLES in either state: set timeout_err, force pmm_valid=0, go to IDLE. No match is reported for that command.
- Undefined: no counter; waits indefinitely; timeout_err tied to 0.

Decomposition:
- Package pmm_pkg holds:
  - opcode constants OP_NOP/OP_WRITE/OP_CHAR/OP_RESET;
  - PMM_MEM_WORDS=517;
  - FSM state enum;
  - command struct {op, addr, data} (80 bits).
- One sub-module: pmm_cmd_fifo (synchronous FIFO, parameterised width/depth).

Test Plan:
- Write op 01 addr 0x0808, data 0xA5 with a PMM model acking after 2 cycles -> pmm_control=0x4808, pmm_data=0xA5; pmm_valid held until ack, then low; next command only after pmm_ready falls.
- Write op 01 addr 0x1028 (word 517) -> no pmm_valid; addr_err=1; following nop issued normally.
- Op 11, then chars 'a','b','c' with the model accepting on 'c' -> one match_valid pulse with match_pos=2; char_count=3; a second op 11 resets char_count to 0.
- Push 6 commands back-to-back with FIFO_DEPTH=4 and a stalled PMM -> s_ready low after 4 accepted; all 6 issued in order once the PMM acks.
- Assert rst while in WAIT_ACK -> next cycle pmm_valid=0, busy=0, s_ready=1, flags cleared.
- With PMM_TIMEOUT_EN and TIMEOUT_CYCLES=16, pmm_ready stuck at 0 -> timeout_err=1 after 16 cycles, FSM in IDLE, next command issued.
